block_interleaver_stream: RTL and testbench

//  Streaming, parametrised bit-group block interleaver with valid/ready on both sides.
//  - Collects N=DATA_W/GRP_W input words into a block.
//  - Emits N transposed words: out word k, bits [i*GRP_W +: GRP_W] = in word i, bits [k*GRP_W +: GRP_W].
//  - Ping-pong buffered. Adds a bypass mode and short-block padding.
//  - Sits between the encoder byte stream and the symbol mapper.

---
 rtl/intlv_pkg.sv | 33 +++
 rtl/block_interleaver_stream_if.sv | 26 ++
 rtl/intlv_bank.sv | 86 ++++++++
 rtl/block_interleaver_stream.sv | 129 ++++++++++++
 tb/tb_block_interleaver_stream.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/intlv_pkg.sv
// rtl/intlv_pkg.sv - shared types, depth derivation and group transpose for the block interleaver
`timescale 1ns/1ps
package intlv_pkg;

    localparam int INTLV_MAX_W = 32;
    localparam int INTLV_MAX_N = 16;

    typedef logic bank_sel_t;

    function automatic int intlv_depth(input int data_w, input int grp_w);
        return data_w / grp_w;
    endfunction

    // Output word k gathers group k of every stored word; group i lands at bit i*grp_w.
    function automatic logic [INTLV_MAX_W-1:0] intlv_transpose(
        input logic [INTLV_MAX_N-1:0][INTLV_MAX_W-1:0] words,
        input int                                      k,
        input int                                      data_w,
        input int                                      grp_w
    );
        logic [INTLV_MAX_W-1:0] res;
        res = '0;
        for (int i = 0; i < INTLV_MAX_N; i++) begin
            for (int b = 0; b < INTLV_MAX_W; b++) begin
                if ((i < data_w / grp_w) && (b < grp_w)) begin
                    res[i*grp_w+b] = words[i][k*grp_w+b];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/block_interleaver_stream_if.sv
// rtl/block_interleaver_stream_if.sv - input/output word handshake bundle of the interleaver
`timescale 1ns/1ps
interface block_interleaver_stream_if #(
    parameter int DATA_W = 8
);
    logic              bypass;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              out_pad;

    modport master (
        output bypass, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_pad
    );

    modport slave (
        input  bypass, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_pad
    );
endinterface

// File: rtl/intlv_bank.sv
// rtl/intlv_bank.sv - one N x DATA_W block buffer with write index, zero pad fill and full/pad/bypass flags
`timescale 1ns/1ps
module intlv_bank
    import intlv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int GRP_W  = 2,
    parameter int N      = intlv_depth(DATA_W, GRP_W),
    parameter int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       wr_last_i,
    input  logic                       wr_bypass_i,
    input  logic                       rel_i,
    output logic [N-1:0][DATA_W-1:0]   words_o,
    output logic [IDX_W-1:0]           wr_idx_o,
    output logic                       full_o,
    output logic                       pad_o,
    output logic                       byp_o
);

    logic [N-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     full_q, full_d;
    logic                     pad_q, pad_d;
    logic                     byp_q, byp_d;

    always_comb begin
        mem_d  = mem_q;
        idx_d  = idx_q;
        full_d = full_q;
        pad_d  = pad_q;
        byp_d  = byp_q;
        if (wr_en_i) begin
            mem_d[idx_q] = wr_data_i;
            if (idx_q == '0) begin
                byp_d = wr_bypass_i;
                pad_d = 1'b0;
            end
            if (wr_last_i || (idx_q == IDX_W'(N-1))) begin
                full_d = 1'b1;
                idx_d  = '0;
                if (idx_q != IDX_W'(N-1)) begin
                    pad_d = 1'b1;
                end
                // Stale words from an earlier block must not leak into a short block.
                for (int j = 0; j < N; j++) begin
                    if (j > int'(idx_q)) begin
                        mem_d[j] = '0;
                    end
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        if (rel_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
            pad_q  <= 1'b0;
            byp_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            idx_q  <= idx_d;
            full_q <= full_d;
            pad_q  <= pad_d;
            byp_q  <= byp_d;
        end
    end

    assign words_o  = mem_q;
    assign wr_idx_o = idx_q;
    assign full_o   = full_q;
    assign pad_o    = pad_q;
    assign byp_o    = byp_q;

endmodule

// File: rtl/block_interleaver_stream.sv
// rtl/block_interleaver_stream.sv - ping-pong bit-group block interleaver; INTLV_STATS_EN adds blk_cnt
`timescale 1ns/1ps
module block_interleaver_stream
    import intlv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int GRP_W  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    block_interleaver_stream_if.slave   bus,
    output logic                        busy
`ifdef INTLV_STATS_EN
    ,
    output logic [15:0]                 blk_cnt
`endif
);

    localparam int N     = intlv_depth(DATA_W, GRP_W);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    bank_sel_t        wr_bnk_q, wr_bnk_d;
    bank_sel_t        rd_bnk_q, rd_bnk_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;

    logic [1:0]               full, pad, byp, wr_en, rel;
    logic [N-1:0][DATA_W-1:0] words [2];
    logic [IDX_W-1:0]         widx  [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        intlv_bank #(
            .DATA_W (DATA_W),
            .GRP_W  (GRP_W),
            .N      (N),
            .IDX_W  (IDX_W)
        ) u_bank (
            .clk         (clk),
            .rst_n       (rst_n),
            .wr_en_i     (wr_en[b]),
            .wr_data_i   (bus.in_data),
            .wr_last_i   (bus.in_last),
            .wr_bypass_i (bus.bypass),
            .rel_i       (rel[b]),
            .words_o     (words[b]),
            .wr_idx_o    (widx[b]),
            .full_o      (full[b]),
            .pad_o       (pad[b]),
            .byp_o       (byp[b])
        );
    end

    logic accept, wr_done, xfer, rd_final;

    assign bus.in_ready  = !full[wr_bnk_q];
    assign accept        = bus.in_valid && bus.in_ready;
    assign wr_done       = accept && (bus.in_last || (widx[wr_bnk_q] == IDX_W'(N-1)));
    assign bus.out_valid = full[rd_bnk_q];
    assign xfer          = bus.out_valid && bus.out_ready;
    assign rd_final      = xfer && (rd_idx_q == IDX_W'(N-1));
    assign bus.out_last  = bus.out_valid && (rd_idx_q == IDX_W'(N-1));
    assign bus.out_pad   = bus.out_valid && pad[rd_bnk_q];
    assign busy          = (|full) || (widx[wr_bnk_q] != '0);

    always_comb begin
        wr_en           = '0;
        rel             = '0;
        wr_en[wr_bnk_q] = accept;
        rel[rd_bnk_q]   = rd_final;
        wr_bnk_d        = wr_done ? ~wr_bnk_q : wr_bnk_q;
        rd_bnk_d        = rd_bnk_q;
        rd_idx_d        = rd_idx_q;
        if (xfer) begin
            if (rd_final) begin
                rd_idx_d = '0;
                rd_bnk_d = ~rd_bnk_q;
            end else begin
                rd_idx_d = rd_idx_q + 1'b1;
            end
        end
    end

    // Output word is derived only from bank contents and read state, never from in_*.
    logic [INTLV_MAX_N-1:0][INTLV_MAX_W-1:0] wide;
    logic [DATA_W-1:0]                       tw;
    logic [DATA_W-1:0]                       out_word;

    always_comb begin
        wide = '0;
        for (int i = 0; i < N; i++) begin
            wide[i][DATA_W-1:0] = words[rd_bnk_q][i];
        end
        tw       = DATA_W'(intlv_transpose(wide, int'(rd_idx_q), DATA_W, GRP_W));
        out_word = '0;
        if (bus.out_valid) begin
            out_word = byp[rd_bnk_q] ? words[rd_bnk_q][rd_idx_q] : tw;
        end
    end

    assign bus.out_data = out_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bnk_q <= 1'b0;
            rd_bnk_q <= 1'b0;
            rd_idx_q <= '0;
        end else begin
            wr_bnk_q <= wr_bnk_d;
            rd_bnk_q <= rd_bnk_d;
            rd_idx_q <= rd_idx_d;
        end
    end

`ifdef INTLV_STATS_EN
    logic [15:0] blk_cnt_q, blk_cnt_d;

    assign blk_cnt_d = rd_final ? blk_cnt_q + 16'd1 : blk_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_block_interleaver_stream.sv
// tb/tb_block_interleaver_stream.sv - scoreboard bench for block_interleaver_stream with a reference model
`timescale 1ns/1ps
module tb_block_interleaver_stream;

    localparam int DW = 8;
    localparam int GW = 2;
    localparam int N  = DW / GW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
`ifdef INTLV_STATS_EN
    logic [15:0] blk_cnt;
`endif

    always #5 clk = ~clk;

    block_interleaver_stream_if #(.DATA_W(DW)) bus();

    block_interleaver_stream #(.DATA_W(DW), .GRP_W(GW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
`ifdef INTLV_STATS_EN
        ,
        .blk_cnt (blk_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [9:0]    exp_q[$];
    logic [9:0]    obs_q[$];
    logic [DW-1:0] blk[$];
    bit            blk_byp;
    bit            rand_rdy  = 1'b0;
    bit            rdy_force = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] b[$], input int k, input bit byp);
        logic [DW-1:0] r;
        int            v;
        if (byp) return b[k];
        r = '0;
        for (int i = 0; i < N; i++) begin
            v = (int'(b[i]) >> (k * GW)) & ((1 << GW) - 1);
            r = r | DW'(v << (i * GW));
        end
        return r;
    endfunction

    task automatic model_accept(input logic [DW-1:0] d, input bit last, input bit byp);
        bit pad;
        if (blk.size() == 0) blk_byp = byp;
        blk.push_back(d);
        if (last || blk.size() == N) begin
            pad = (blk.size() < N);
            while (blk.size() < N) blk.push_back('0);
            for (int k = 0; k < N; k++) begin
                exp_q.push_back({pad, (k == N - 1), ref_word(blk, k, blk_byp)});
            end
            blk.delete();
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input bit last, input bit byp);
        int t = 0;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.bypass   = byp;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", bus.in_ready, 1);
        end else begin
            model_accept(d, last, byp);
            @(negedge clk);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic chk_obs(input string name, input logic [9:0] e[$]);
        chk({name, "_count"}, obs_q.size(), e.size());
        for (int i = 0; i < e.size() && i < obs_q.size(); i++) begin
            chk(name, obs_q[i], e[i]);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  bus.in_ready,  1);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_data"},  bus.out_data,  0);
        chk({tag, "_out_last"},  bus.out_last,  0);
        chk({tag, "_out_pad"},   bus.out_pad,   0);
        chk({tag, "_busy"},      busy,          0);
`ifdef INTLV_STATS_EN
        chk({tag, "_blk_cnt"},   blk_cnt,       0);
`endif
    endtask

    task automatic do_reset(input string tag);
        idle();
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals(tag);
        exp_q.delete();
        blk.delete();
        obs_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    logic [DW-1:0] prev_data;
    bit            hold = 1'b0;
    logic [9:0]    e_mon;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data",  bus.out_data,  prev_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", bus.out_valid, 0);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("out_data", bus.out_data, e_mon[7:0]);
                    chk("out_last", bus.out_last, e_mon[8]);
                    chk("out_pad",  bus.out_pad,  e_mon[9]);
                end
                obs_q.push_back({bus.out_pad, bus.out_last, bus.out_data});
            end
            hold      = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] eq[$];
        int         n;
        int         t;
        int         len;

        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        bus.bypass   = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        obs_q.delete();
        send(8'h1B, 0, 0); send(8'hE4, 0, 0); send(8'h00, 0, 0); send(8'hFF, 0, 0);
        idle();
        drain();
        eq = '{10'h0C3, 10'h0C6, 10'h0C9, 10'h1CC};
        chk_obs("t1_transpose", eq);

        obs_q.delete();
        send(8'hFF, 1, 0);
        idle();
        drain();
        eq = '{10'h203, 10'h203, 10'h203, 10'h303};
        chk_obs("t2_pad", eq);
        obs_q.delete();
        for (int i = 0; i < N; i++) send(DW'($urandom), 0, 0);
        idle();
        drain();
        for (int i = 0; i < obs_q.size(); i++) chk("t2_next_unpadded", obs_q[i][9], 0);

        rdy_force = 1'b0;
        repeat (2) @(negedge clk);
        obs_q.delete();
        for (int i = 0; i < 2 * N; i++) send(DW'($urandom), 0, 0);
        idle();
        chk("t3_in_ready_both_full", bus.in_ready, 0);
        rdy_force = 1'b1;
        n = 0;
        t = 0;
        while (!bus.in_ready && t < 100) begin
            if (bus.out_valid && bus.out_ready) n++;
            @(negedge clk);
            t++;
        end
        chk("t3_outputs_before_ready", n, N);
        send(8'h5A, 1, 0);
        idle();
        drain();
        chk("t3_total_out", obs_q.size(), 3 * N);

        obs_q.delete();
        send(8'h1B, 0, 1); send(8'hE4, 0, 1); send(8'h00, 0, 0); send(8'hFF, 0, 0);
        idle();
        drain();
        eq = '{10'h01B, 10'h0E4, 10'h000, 10'h1FF};
        chk_obs("t4_bypass", eq);

        send(8'h33, 0, 0); send(8'h44, 0, 0);
        idle();
        chk("t5_busy_partial", busy, 1);
        do_reset("t5_reset");
        send(8'h1B, 0, 0); send(8'hE4, 0, 0); send(8'h00, 0, 0); send(8'hFF, 0, 0);
        idle();
        drain();
        eq = '{10'h0C3, 10'h0C6, 10'h0C9, 10'h1CC};
        chk_obs("t5_after_reset", eq);

`ifdef INTLV_STATS_EN
        do_reset("t6_reset");
        fork
            begin
                for (int i = 0; i < 3 * N; i++) send(DW'($urandom), 0, 0);
                idle();
            end
            begin
                int w    = 0;
                int gaps = 0;
                while (!bus.out_valid && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                for (int i = 0; i < 3 * N; i++) begin
                    if (!bus.out_valid) gaps++;
                    @(negedge clk);
                end
                chk("t6_no_bubbles", gaps, 0);
            end
        join
        drain();
        chk("t6_blk_cnt", blk_cnt, 3);
`endif

        rand_rdy = 1'b1;
        for (int b = 0; b < 40; b++) begin
            len = $urandom_range(1, N);
            for (int w = 0; w < len; w++) begin
                if ($urandom_range(0, 2) == 0) begin
                    idle();
                    repeat ($urandom_range(1, 2)) @(negedge clk);
                end
                send(DW'($urandom), (w == len - 1) && (len < N || $urandom_range(0, 1) == 1),
                     1'($urandom_range(0, 1)));
            end
        end
        idle();
        rand_rdy = 1'b0;
        rdy_force = 1'b1;
        drain();
        chk("model_partial_empty", blk.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
